voice_mixer: RTL and testbench

VOICE_MIXER -- requirements
Module: voice_mixer

---
 rtl/voice_mixer.sv | 173 +++++++++++++++++
 tb/tb_voice_mixer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// voice_mixer: wavetable voice mixer.
// On each accepted sample tick, walks up to NUM_VOICES voice slots, reads one
// wavetable sample per active slot through a fixed-latency BRAM port, sums the
// signed samples exactly and presents the result with a one-cycle valid pulse.
//
// Ports
//   clk_in                system clock (rising edge)
//   rst_n_in              asynchronous active-low reset
//   sample_tick_in        one-cycle request for a mixed sample
//   addr_in               NUM_NOTES x ADDR_WIDTH per-note wavetable address
//   active_voices_idx_in  NUM_VOICES x 5 note index per slot (5'b11111 = empty)
//   num_voices_in         number of valid voice slots
//   bram_addr_out         wavetable read address
//   bram_data_in          signed wavetable data, BRAM_LATENCY cycles after address
//   mix_out               signed mix result
//   mix_valid_out         one-cycle pulse when mix_out updates
//   busy_out              high while a mix is in progress
//   overrun_out           sticky: tick arrived while busy
//
// state | meaning
// IDLE  | waiting for sample_tick_in
// ISSUE | one voice slot per cycle, address presented on bram_addr_out
// DRAIN | waiting for outstanding reads to return
// DONE  | accumulator is final; publish it on the next edge

module voice_mixer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_NOTES    = 24,
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_WIDTH = 8,
    parameter int BRAM_LATENCY = 2,
    parameter int OUT_WIDTH    = SAMPLE_WIDTH + 3
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             sample_tick_in,
    input  logic [NUM_NOTES*ADDR_WIDTH-1:0]  addr_in,
    input  logic [NUM_VOICES*5-1:0]          active_voices_idx_in,
    input  logic [3:0]                       num_voices_in,
    output logic [ADDR_WIDTH-1:0]            bram_addr_out,
    input  logic [SAMPLE_WIDTH-1:0]          bram_data_in,
    output logic [OUT_WIDTH-1:0]             mix_out,
    output logic                             mix_valid_out,
    output logic                             busy_out,
    output logic                             overrun_out
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                           r_state;
    state_t                           w_state_next;
    logic [NUM_NOTES*ADDR_WIDTH-1:0]  r_addr_snap;
    logic [NUM_VOICES*5-1:0]          r_idx_snap;
    logic [3:0]                       r_n;
    logic [3:0]                       r_slot;
    logic [ADDR_WIDTH-1:0]            r_addr;
    logic [OUT_WIDTH-1:0]             r_acc;
    logic [OUT_WIDTH-1:0]             r_mix;
    logic                             r_mix_valid;
    logic                             r_overrun;
    logic [BRAM_LATENCY-1:0]          r_tag;

    logic [3:0]                       w_n;
    logic [4:0]                       w_cur_idx;
    logic [4:0]                       w_nxt_idx;
    logic [4:0]                       w_first_idx;
    logic                             w_tag_in;
    logic                             w_accept;
    logic [BRAM_LATENCY:0]            w_tag_next;
    logic [OUT_WIDTH-1:0]             w_sample_ext;

    function automatic logic [4:0] f_slot_idx(input logic [NUM_VOICES*5-1:0] tbl,
                                              input logic [3:0] k);
        logic [4:0] v;
        v = 5'h1f;
        for (int i = 0; i < NUM_VOICES; i++)
            if (k == 4'(i)) v = tbl[i*5 +: 5];
        return v;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] f_note_addr(
            input logic [NUM_NOTES*ADDR_WIDTH-1:0] tbl, input logic [4:0] idx);
        logic [ADDR_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_NOTES; i++)
            if (idx == 5'(i)) v = tbl[i*ADDR_WIDTH +: ADDR_WIDTH];
        return v;
    endfunction

    function automatic logic f_valid(input logic [4:0] idx);
        return idx < 5'(NUM_NOTES);
    endfunction

    assign w_n          = (num_voices_in > 4'(NUM_VOICES)) ? 4'(NUM_VOICES) : num_voices_in;
    assign w_cur_idx    = f_slot_idx(r_idx_snap, r_slot);
    assign w_nxt_idx    = f_slot_idx(r_idx_snap, r_slot + 4'd1);
    assign w_first_idx  = active_voices_idx_in[4:0];
    // Oldest tag falls off the top; bit 0 is the tag issued this cycle.
    assign w_tag_next   = {r_tag, w_tag_in};
    assign w_sample_ext = {{(OUT_WIDTH-SAMPLE_WIDTH){bram_data_in[SAMPLE_WIDTH-1]}}, bram_data_in};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (sample_tick_in) w_state_next = (w_n == 4'd0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (r_slot == r_n - 4'd1) w_state_next = S_DRAIN;
            // Leave once the only tag still in flight is the one consumed this edge.
            S_DRAIN: if (w_tag_next[BRAM_LATENCY-1:0] == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_out = (r_state != S_IDLE);
        w_accept = (r_state == S_IDLE) && sample_tick_in;
        w_tag_in = (r_state == S_ISSUE) && f_valid(w_cur_idx);
    end

    // The address register runs one slot ahead: it is loaded on the edge that
    // enters a slot's ISSUE cycle, so the read for slot k is on the bus during
    // that cycle. Slot 0 is loaded from the live inputs on the accepting edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_addr_snap <= '0;
            r_idx_snap  <= '0;
            r_n         <= '0;
            r_slot      <= '0;
            r_addr      <= '0;
            r_acc       <= '0;
            r_mix       <= '0;
            r_mix_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_tag       <= '0;
        end else begin
            r_tag       <= w_tag_next[BRAM_LATENCY-1:0];
            r_mix_valid <= 1'b0;
            if (sample_tick_in && r_state != S_IDLE) r_overrun <= 1'b1;

            if (w_accept) begin
                r_addr_snap <= addr_in;
                r_idx_snap  <= active_voices_idx_in;
                r_n         <= w_n;
                r_slot      <= 4'd0;
                if (w_n != 4'd0 && f_valid(w_first_idx))
                    r_addr <= f_note_addr(addr_in, w_first_idx);
            end else if (r_state == S_ISSUE) begin
                r_slot <= r_slot + 4'd1;
                if ((r_slot + 4'd1) < r_n && f_valid(w_nxt_idx))
                    r_addr <= f_note_addr(r_addr_snap, w_nxt_idx);
            end

            if (w_accept)                    r_acc <= '0;
            else if (r_tag[BRAM_LATENCY-1])  r_acc <= r_acc + w_sample_ext;

            if (r_state == S_DONE) begin
                r_mix       <= r_acc;
                r_mix_valid <= 1'b1;
            end
        end
    end

    assign bram_addr_out = r_addr;
    assign mix_out       = r_mix;
    assign mix_valid_out = r_mix_valid;
    assign overrun_out   = r_overrun;

endmodule

// File: tb/tb_voice_mixer.sv
module tb_voice_mixer;

    logic          clk;
    logic          rst_n;
    logic          tick;
    logic [191:0]  addr_in;
    logic [39:0]   idx_in;
    logic [3:0]    num_in;
    logic [7:0]    bram_addr;
    logic [7:0]    bram_data;
    logic [10:0]   mix;
    logic          valid;
    logic          busy;
    logic          overrun;

    logic [7:0]    mem [256];
    logic [7:0]    d1;
    logic [7:0]    addr_log [32];
    logic          busy0;

    int n_checks = 0;
    int n_fail   = 0;

    voice_mixer dut (
        .clk_in               (clk),
        .rst_n_in             (rst_n),
        .sample_tick_in       (tick),
        .addr_in              (addr_in),
        .active_voices_idx_in (idx_in),
        .num_voices_in        (num_in),
        .bram_addr_out        (bram_addr),
        .bram_data_in         (bram_data),
        .mix_out              (mix),
        .mix_valid_out        (valid),
        .busy_out             (busy),
        .overrun_out          (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle-latency wavetable memory.
    always @(posedge clk) begin
        d1        <= mem[bram_addr];
        bram_data <= d1;
    end

    task automatic set_note(input int i, input logic [7:0] a);
        addr_in[i*8 +: 8] = a;
    endtask

    task automatic set_slot(input int k, input logic [4:0] ix);
        idx_in[k*5 +: 5] = ix;
    endtask

    task automatic base_config();
        for (int i = 0; i < 24; i++) set_note(i, 8'(i));
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        idx_in = {8{5'h1f}};
        set_note(0, 8'h10);  mem[8'h10] = 8'd10;
        set_note(5, 8'h25);  mem[8'h25] = 8'hEC;   // -20
        set_note(23, 8'h37); mem[8'h37] = 8'd7;
        set_slot(0, 5'd0); set_slot(1, 5'd5); set_slot(2, 5'd23);
        num_in = 4'd3;
    endtask

    // Caller is at a negedge. Tick is sampled at the next posedge (edge T);
    // cycle c is observed at the negedge following edge T+c.
    task automatic do_mix(input int extra, input bit scramble,
                          output int lat_first, output int lat_last,
                          output int vcnt, output int mix_first);
        lat_first = -1; lat_last = -1; vcnt = 0; mix_first = 0;
        tick = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            addr_log[c] = bram_addr;
            if (c == 0) busy0 = busy;
            if (valid) begin
                vcnt++;
                if (lat_first < 0) begin
                    lat_first = c;
                    mix_first = int'($signed(mix));
                end
                lat_last = c;
            end
            tick = (c + 1 == extra);
            if (scramble && c == 0) begin
                addr_in = ~addr_in;
                idx_in  = {8{5'd1}};
                num_in  = 4'd8;
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 1'b0;
        base_config();
        repeat (2) @(negedge clk);
        n_checks++; if (mix !== 11'd0)   begin n_fail++; $display("FAIL reset_mix: got %0h expected 0", mix); end
        n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++; if (bram_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", bram_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_three_voices();
        int lf, ll, vc, m;
        base_config();
        do_mix(0, 1'b0, lf, ll, vc, m);
        n_checks++; if (lf !== 6)  begin n_fail++; $display("FAIL three_latency: got %0d expected 6", lf); end
        n_checks++; if (m !== -3)  begin n_fail++; $display("FAIL three_mix: got %0d expected -3", m); end
        n_checks++; if (vc !== 1)  begin n_fail++; $display("FAIL three_pulses: got %0d expected 1", vc); end
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL three_busy: got %b expected 1", busy0); end
        n_checks++; if (addr_log[0] !== 8'h10) begin n_fail++; $display("FAIL three_addr0: got %0h expected 10", addr_log[0]); end
        n_checks++; if (addr_log[1] !== 8'h25) begin n_fail++; $display("FAIL three_addr1: got %0h expected 25", addr_log[1]); end
        n_checks++; if (addr_log[2] !== 8'h37) begin n_fail++; $display("FAIL three_addr2: got %0h expected 37", addr_log[2]); end
        n_checks++; if (addr_log[5] !== 8'h37) begin n_fail++; $display("FAIL three_addr_hold: got %0h expected 37", addr_log[5]); end
    endtask

    task automatic test_zero_voices();
        int lf, ll, vc, m;
        base_config();
        num_in = 4'd0;
        do_mix(0, 1'b0, lf, ll, vc, m);
        n_checks++; if (lf !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d expected 1", lf); end
        n_checks++; if (m !== 0)  begin n_fail++; $display("FAIL zero_mix: got %0d expected 0", m); end
        n_checks++; if (addr_log[0] !== 8'h37 || addr_log[3] !== 8'h37)
            begin n_fail++; $display("FAIL zero_addr: got %0h/%0h expected 37", addr_log[0], addr_log[3]); end
    endtask

    task automatic test_snapshot();
        int lf, ll, vc, m;
        base_config();
        do_mix(0, 1'b1, lf, ll, vc, m);
        n_checks++; if (m !== -3) begin n_fail++; $display("FAIL snap_mix: got %0d expected -3", m); end
        n_checks++; if (lf !== 6) begin n_fail++; $display("FAIL snap_latency: got %0d expected 6", lf); end
        n_checks++; if (addr_log[1] !== 8'h25 || addr_log[2] !== 8'h37)
            begin n_fail++; $display("FAIL snap_addr: got %0h/%0h expected 25/37", addr_log[1], addr_log[2]); end
        base_config();
    endtask

    task automatic test_eight_voices();
        int lf, ll, vc, m;
        base_config();
        for (int k = 0; k < 8; k++) begin
            set_note(k, 8'(8'h80 + k)); set_slot(k, 5'(k)); mem[8'h80 + k] = 8'h80;
        end
        num_in = 4'd8;
        do_mix(0, 1'b0, lf, ll, vc, m);
        n_checks++; if (m !== -1024) begin n_fail++; $display("FAIL eight_min_mix: got %0d expected -1024", m); end
        n_checks++; if (lf !== 11)   begin n_fail++; $display("FAIL eight_latency: got %0d expected 11", lf); end
        for (int k = 0; k < 8; k++) mem[8'h80 + k] = 8'h7F;
        @(negedge clk);
        do_mix(0, 1'b0, lf, ll, vc, m);
        n_checks++; if (m !== 1016) begin n_fail++; $display("FAIL eight_max_mix: got %0d expected 1016", m); end
    endtask

    task automatic test_clamp();
        int lf, ll, vc, m;
        for (int k = 0; k < 8; k++) mem[8'h80 + k] = 8'(k + 1);
        num_in = 4'd12;
        @(negedge clk);
        do_mix(0, 1'b0, lf, ll, vc, m);
        n_checks++; if (m !== 36)  begin n_fail++; $display("FAIL clamp_mix: got %0d expected 36", m); end
        n_checks++; if (lf !== 11) begin n_fail++; $display("FAIL clamp_latency: got %0d expected 11", lf); end
        n_checks++; if (addr_log[7] !== 8'h87 || addr_log[8] !== 8'h87)
            begin n_fail++; $display("FAIL clamp_addr: got %0h/%0h expected 87/87", addr_log[7], addr_log[8]); end
    endtask

    task automatic test_invalid_slot();
        int lf, ll, vc, m;
        base_config();
        set_note(2, 8'h42); mem[8'h42] = 8'd50;
        set_note(4, 8'h44); mem[8'h44] = 8'hF7;   // -9
        set_slot(0, 5'd2); set_slot(1, 5'd30); set_slot(2, 5'd4);
        @(negedge clk);
        do_mix(0, 1'b0, lf, ll, vc, m);
        n_checks++; if (m !== 41) begin n_fail++; $display("FAIL invalid_mix: got %0d expected 41", m); end
        n_checks++; if (lf !== 6) begin n_fail++; $display("FAIL invalid_latency: got %0d expected 6", lf); end
        n_checks++; if (addr_log[1] !== 8'h42 || addr_log[2] !== 8'h44)
            begin n_fail++; $display("FAIL invalid_addr: got %0h/%0h expected 42/44", addr_log[1], addr_log[2]); end
    endtask

    task automatic test_back_to_back();
        int lf, ll, vc, m;
        base_config();
        @(negedge clk);
        do_mix(7, 1'b0, lf, ll, vc, m);
        n_checks++; if (vc !== 2)  begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", vc); end
        n_checks++; if (ll !== 13) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 13", ll); end
        n_checks++; if ($signed(mix) !== -3) begin n_fail++; $display("FAIL b2b_mix: got %0d expected -3", $signed(mix)); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_overrun();
        int lf, ll, vc, m;
        do_mix(3, 1'b0, lf, ll, vc, m);
        n_checks++; if (vc !== 1)  begin n_fail++; $display("FAIL overrun_pulses: got %0d expected 1", vc); end
        n_checks++; if (m !== -3)  begin n_fail++; $display("FAIL overrun_mix: got %0d expected -3", m); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
        repeat (5) @(negedge clk);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_mid_mix();
        int lf, ll, vc, m;
        int pulses;
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mix !== 11'd0 || valid !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL midrst_outputs: got mix=%0h valid=%b busy=%b expected 0", mix, valid, busy); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
        n_checks++; if (bram_addr !== 8'd0) begin n_fail++; $display("FAIL midrst_addr: got %0h expected 0", bram_addr); end
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_pulse: got %0d expected 0", pulses); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_mix(0, 1'b0, lf, ll, vc, m);
        n_checks++; if (lf !== 6 || vc !== 1)
            begin n_fail++; $display("FAIL midrst_first_edge: got latency %0d pulses %0d expected 6/1", lf, vc); end
        n_checks++; if (m !== -3) begin n_fail++; $display("FAIL midrst_remix: got %0d expected -3", m); end
    endtask

    task automatic test_done_tick();
        int lf, ll, vc, m;
        do_mix(6, 1'b0, lf, ll, vc, m);
        n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL done_tick_pulses: got %0d expected 1", vc); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL done_tick_overrun: got %b expected 1", overrun); end
    endtask

    initial begin
        test_reset();
        test_three_voices();
        test_zero_voices();
        test_snapshot();
        test_eight_voices();
        test_clamp();
        test_invalid_slot();
        test_back_to_back();
        test_overrun();
        test_reset_mid_mix();
        test_done_tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
